// File: rtl/cpu16_pkg.sv
// Shared types for the 16-bit CPU front end: word width, fetch FSM states and
// the instruction-queue entry layout.
package cpu16_pkg;

  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } ifq_state_e;

  typedef struct packed {
    word_t data;
    word_t pc;
  } ifq_entry_t;

endpackage

// File: rtl/ifetch_queue_if.sv
// Bundles the instruction-memory request port, the decode-side queue head and
// the redirect input of the fetch unit.
interface ifetch_queue_if;
  import cpu16_pkg::*;

  logic  imem_req;
  word_t imem_addr;
  logic  imem_ack;
  word_t imem_rdata;
  logic  inst_valid;
  word_t inst_data;
  word_t inst_pc;
  logic  inst_ready;
  logic  redirect;
  word_t redirect_pc;

  modport master (
    output imem_req, imem_addr, inst_valid, inst_data, inst_pc,
    input  imem_ack, imem_rdata, inst_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_data, inst_pc,
    output imem_ack, imem_rdata, inst_ready, redirect, redirect_pc
  );

endinterface

// File: rtl/ifq_fifo.sv
// Circular instruction buffer with synchronous push/pop/flush; the head entry is
// read straight from the register array so it is visible the cycle after its push.
module ifq_fifo
  import cpu16_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  ifq_entry_t       push_entry,
  input  logic             pop,
  input  logic             flush,
  output ifq_entry_t       head_entry,
  output logic             head_valid,
  output logic [CNT_W-1:0] count
);

  ifq_entry_t       mem_q [DEPTH];
  ifq_entry_t       mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_en;
  logic             rd_en;

  // Flush wins over both ports; full/empty guards keep the pointers coherent.
  assign wr_en = push & ~flush & (count_q != CNT_W'(DEPTH));
  assign rd_en = pop & ~flush & (count_q != '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_entry = mem_q[rd_ptr_q];
  assign head_valid = (count_q != '0);
  assign count      = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction prefetch unit: issues sequential fetches into ifq_fifo, flushes on
// redirect. Optional stall counter output enabled with `define IFQ_STALL_CNT_EN.
module ifetch_queue
  import cpu16_pkg::*;
#(
  parameter int    DEPTH    = 4,
  parameter word_t RESET_PC = 16'h0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ifetch_queue_if.master       bus
`ifdef IFQ_STALL_CNT_EN
  ,
  output logic [WORD_W-1:0]    stall_cnt
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  ifq_state_e       state_q, state_d;
  word_t            fetch_pc_q, fetch_pc_d;
  word_t            addr_q, addr_d;
  logic             req_q, req_d;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             ack_seen;
  logic             push;
  logic             pop;
  logic             can_issue;
  logic             issue;
  logic             head_valid;
  ifq_entry_t       push_entry;
  ifq_entry_t       head_entry;

  // An ack only counts against an outstanding request.
  assign ack_seen   = req_q & bus.imem_ack;
  assign push       = (state_q == WAIT) & ack_seen & ~bus.redirect;
  assign pop        = head_valid & bus.inst_ready;
  assign count_next = count + CNT_W'(push) - CNT_W'(pop);
  assign can_issue  = (count_next < CNT_W'(DEPTH)) & ~bus.redirect;
  assign push_entry = '{data: bus.imem_rdata, pc: addr_q};

  ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (bus.redirect),
    .head_entry (head_entry),
    .head_valid (head_valid),
    .count      (count)
  );

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;
    fetch_pc_d = fetch_pc_q;
    issue      = 1'b0;
    unique case (state_q)
      IDLE: issue = can_issue;
      WAIT: begin
        if (ack_seen) begin
          if (can_issue) begin
            issue = 1'b1;
          end else begin
            state_d = IDLE;
            req_d   = 1'b0;
          end
        end else if (bus.redirect) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (ack_seen) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
    if (issue) begin
      state_d    = WAIT;
      req_d      = 1'b1;
      addr_d     = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 16'd1;
    end
    if (bus.redirect) begin
      fetch_pc_d = bus.redirect_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      addr_q     <= '0;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  assign bus.imem_req   = req_q;
  assign bus.imem_addr  = addr_q;
  assign bus.inst_valid = head_valid;
  assign bus.inst_data  = head_entry.data;
  assign bus.inst_pc    = head_entry.pc;

`ifdef IFQ_STALL_CNT_EN
  word_t stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.redirect) begin
      stall_cnt_d = '0;
    end else if (req_q && !bus.imem_ack && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: latency-programmable memory responder,
// in-order pc/data scoreboard, directed corner sequences and a vector table.
module tb_ifetch_queue;

  localparam logic [15:0] RESET_PC = 16'h0000;

  logic clk;
  logic rst_n;
  ifetch_queue_if bus ();
`ifdef IFQ_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  ifetch_queue #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus)
`ifdef IFQ_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int lat      = 0;
  int wc       = 0;
  bit stray_ack = 1'b0;
  int push_cnt = 0;
  int pop_cnt  = 0;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] data;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int          lat;
    bit          ready;
    logic [15:0] start_pc;
    int          exp_pops;
    bit          exp_req;
    bit          exp_valid;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic void sb_restart(input logic [15:0] pc);
    logic [15:0] p;
    p = pc;
    sb.delete();
    for (int i = 0; i < 128; i++) begin
      sb.push_back('{pc: p, data: p + 16'h1000});
      p = p + 16'd1;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb_restart(RESET_PC);
    push_cnt = 0;
    pop_cnt  = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Memory responder: acks after `lat` wait cycles, data = addr + 0x1000.
  initial begin
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      if (stray_ack && !bus.imem_req) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 16'hDEAD;
        wc = 0;
      end else if (bus.imem_req && rst_n) begin
        if (wc >= lat) begin
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = bus.imem_addr + 16'h1000;
          wc = 0;
        end else begin
          bus.imem_ack = 1'b0;
          wc++;
        end
      end else begin
        bus.imem_ack = 1'b0;
        wc = 0;
      end
    end
  end

  // Monitor: counts accepted requests and checks every pop against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.imem_req && bus.imem_ack) push_cnt++;
      if (rst_n && !bus.redirect && bus.inst_valid && bus.inst_ready) begin
        pop_cnt++;
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL sb_empty: got pop of pc %h expected none", bus.inst_pc);
        end else begin
          e = sb.pop_front();
          check("pop_pc", {16'h0, bus.inst_pc}, {16'h0, e.pc});
          check("pop_data", {16'h0, bus.inst_data}, {16'h0, e.data});
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got no finish expected finish within 1ms");
    $fatal(1);
  end

  initial begin
    int n;
    vecs[0] = '{lat: 0, ready: 1'b1, start_pc: 16'hFFFE, exp_pops: 18, exp_req: 1'b1, exp_valid: 1'b1};
    vecs[1] = '{lat: 1, ready: 1'b1, start_pc: 16'h2000, exp_pops: 9,  exp_req: 1'b1, exp_valid: 1'b0};
    vecs[2] = '{lat: 2, ready: 1'b1, start_pc: 16'h3FFF, exp_pops: 6,  exp_req: 1'b1, exp_valid: 1'b0};
    vecs[3] = '{lat: 3, ready: 1'b1, start_pc: 16'h0500, exp_pops: 4,  exp_req: 1'b1, exp_valid: 1'b0};
    vecs[4] = '{lat: 0, ready: 1'b0, start_pc: 16'h7000, exp_pops: 0,  exp_req: 1'b0, exp_valid: 1'b1};
    vecs[5] = '{lat: 0, ready: 1'b1, start_pc: 16'h0100, exp_pops: 18, exp_req: 1'b1, exp_valid: 1'b1};

    rst_n           = 1'b0;
    bus.inst_ready  = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 16'h0000;
    sb_restart(RESET_PC);

    // Reset state, before any clock edge.
    #1;
    check("rst_valid", bus.inst_valid, 0);
    check("rst_req", bus.imem_req, 0);
    check("rst_addr", bus.imem_addr, 0);
    check("rst_data", bus.inst_data, 0);
    check("rst_pc", bus.inst_pc, 0);
`ifdef IFQ_STALL_CNT_EN
    check("rst_stall", stall_cnt, 0);
`endif

    // Zero-wait stream after reset: pcs 0..3 one per cycle.
    lat = 0;
    bus.inst_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("first_req", bus.imem_req, 1);
    check("first_addr", bus.imem_addr, {16'h0, RESET_PC});
    for (int k = 0; k < 4; k++) begin
      tick();
      check("stream_valid", bus.inst_valid, 1);
      check("stream_pc", bus.inst_pc, k);
      check("stream_data", bus.inst_data, 32'h1000 + k);
    end

    // Redirect to FFFE: address wrap.
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'hFFFE;
    sb_restart(16'hFFFE);
    tick();
    bus.redirect = 1'b0;
    check("wrap_flush_valid", bus.inst_valid, 0);
    check("wrap_flush_req", bus.imem_req, 0);
    tick(); check("wrap_addr0", bus.imem_addr, 32'hFFFE);
    tick(); check("wrap_addr1", bus.imem_addr, 32'hFFFF);
    tick(); check("wrap_addr2", bus.imem_addr, 32'h0000);
    tick(); check("wrap_addr3", bus.imem_addr, 32'h0001);

    // Back-pressure: exactly DEPTH pushes, then one pop buys one request.
    bus.inst_ready = 1'b0;
    lat = 0;
    do_reset();
    repeat (15) tick();
    check("bp_pushes", push_cnt, 4);
    check("bp_req_low", bus.imem_req, 0);
    check("bp_valid", bus.inst_valid, 1);
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    check("bp_head_after_pop", bus.inst_pc, 1);
    repeat (10) tick();
    check("bp_pushes_after_pop", push_cnt, 5);
    check("bp_req_low_after_pop", bus.imem_req, 0);

    // 3-cycle latency, redirect in second wait cycle: returning word dropped.
    lat = 2;
    bus.inst_ready = 1'b1;
    do_reset();
    tick();
    check("drop_req", bus.imem_req, 1);
    check("drop_addr", bus.imem_addr, 0);
    tick();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0040;
    sb_restart(16'h0040);
    tick();
    bus.redirect = 1'b0;
    stray_ack    = 1'b1;
    check("drop_req_held", bus.imem_req, 1);
    check("drop_addr_held", bus.imem_addr, 0);
    tick();
    stray_ack = 1'b0;
    check("drop_req_fell", bus.imem_req, 0);
    check("drop_valid", bus.inst_valid, 0);
    tick();
    check("drop_new_req", bus.imem_req, 1);
    check("drop_new_addr", bus.imem_addr, 32'h0040);
    pop_cnt = 0;
    repeat (15) tick();
    check("drop_pops", pop_cnt, 4);

    // Redirect, pop and ack on the same edge.
    lat = 1;
    bus.inst_ready = 1'b0;
    do_reset();
    repeat (6) tick();
    check("tri_valid_pre", bus.inst_valid, 1);
    check("tri_req_pre", bus.imem_req, 1);
    bus.inst_ready  = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0080;
    sb_restart(16'h0080);
    tick();
    bus.redirect = 1'b0;
    check("tri_valid", bus.inst_valid, 0);
    check("tri_req_idle", bus.imem_req, 0);
    tick();
    check("tri_next_req", bus.imem_req, 1);
    check("tri_next_addr", bus.imem_addr, 32'h0080);

    // Vector table: each starts from a full, idle queue.
    for (int v = 0; v < 6; v++) begin
      bus.inst_ready = 1'b0;
      n = 0;
      do begin
        tick();
        n++;
      end while (bus.imem_req && n < 100);
      check("vec_quiesce", bus.imem_req, 0);
      lat = vecs[v].lat;
      tick();
      bus.redirect    = 1'b1;
      bus.redirect_pc = vecs[v].start_pc;
      sb_restart(vecs[v].start_pc);
      tick();
      bus.redirect   = 1'b0;
      bus.inst_ready = vecs[v].ready;
      pop_cnt = 0;
      repeat (20) tick();
      $display("vec %0d lat=%0d ready=%0d start=%h pops=%0d req=%0d valid=%0d",
               v, vecs[v].lat, vecs[v].ready, vecs[v].start_pc, pop_cnt,
               bus.imem_req, bus.inst_valid);
      check("vec_pops", pop_cnt, vecs[v].exp_pops);
      check("vec_req", bus.imem_req, vecs[v].exp_req);
      check("vec_valid", bus.inst_valid, vecs[v].exp_valid);
    end

    // Asynchronous reset mid-request.
    lat = 3;
    tick();
    check("arst_pre_req", bus.imem_req, 1);
    #1;
    rst_n = 1'b0;
    sb_restart(RESET_PC);
    #1;
    check("arst_req", bus.imem_req, 0);
    check("arst_addr", bus.imem_addr, 0);
    check("arst_valid", bus.inst_valid, 0);
    check("arst_pc", bus.inst_pc, 0);
    check("arst_data", bus.inst_data, 0);
`ifdef IFQ_STALL_CNT_EN
    check("arst_stall", stall_cnt, 0);
`endif
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("arst_first_req", bus.imem_req, 1);
    check("arst_first_addr", bus.imem_addr, {16'h0, RESET_PC});

`ifdef IFQ_STALL_CNT_EN
    // Two-cycle latency: one stall cycle per request; redirect clears.
    lat = 1;
    bus.inst_ready = 1'b1;
    do_reset();
    repeat (2) tick();
    check("stall_1", stall_cnt, 1);
    repeat (2) tick();
    check("stall_2", stall_cnt, 2);
    repeat (2) tick();
    check("stall_3", stall_cnt, 3);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0200;
    sb_restart(16'h0200);
    tick();
    bus.redirect = 1'b0;
    check("stall_clear", stall_cnt, 0);
`endif

    bus.inst_ready = 1'b0;
    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
